// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer with a three-state FETCH / EXEC / HALT loop.
//   Each instruction is fetched from instruction memory, spends exactly one
//   cycle in execute, and then either advances the pc, takes a jump, or parks
//   the sequencer in HALT until resume.
//
// Ports
//   clk          in   1   clock, all state changes on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   jump         in   1   taken-jump decision, sampled in EXEC
//   jump_target  in  16   jump destination, sampled in EXEC
//   halt         in   1   halt request, sampled in EXEC only
//   resume       in   1   leave HALT (wins over halt)
//   imem_req     out  1   fetch request
//   imem_addr    out 16   fetch address (always the pc)
//   imem_ack     in   1   imem_data is valid this cycle
//   imem_data    in  16   fetched instruction word
//   pc           out 16   current program counter
//   instr        out 16   latched instruction
//   instr_valid  out  1   instr is in execute this cycle
//   halted       out  1   sequencer is in HALT
//   retired      out 16   executed-instruction count (wraps)
//   state_dbg    out  2   raw FSM state for checkers (0=FETCH 1=EXEC 2=HALT)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [15:0] RESET_PC          = 16'h0000,
    parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] retired,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] retired_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic        halted_q;

    logic        self_jump_d;
    logic [15:0] pc_d;
    logic [15:0] retired_d;

    // Next-value datapath used on the EXEC edge.
    always_comb begin
        self_jump_d = HALT_ON_SELF_JUMP && jump && (jump_target == pc_q);
        pc_d        = jump ? jump_target : (pc_q + 16'd1);
        retired_d   = retired_q + 16'd1;
    end

    // Handshake: imem_req is a request-valid held high for the whole FETCH;
    // imem_ack acts as the one-cycle response strobe. A transfer happens on
    // the rising edge where imem_req=1 and imem_ack=1; ack at any other time
    // (EXEC, HALT, reset, or the first cycle after reset) is ignored.
    //
    // Outputs are registered and are rewritten together with state_q, so they
    // always reflect the state only. imem_req stays low in the first FETCH
    // cycle after reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            retired_q     <= 16'h0000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req_q && imem_ack) begin
                        instr_q       <= imem_data;
                        state_q       <= S_EXEC;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else begin
                        imem_req_q    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    retired_q     <= retired_d;
                    instr_valid_q <= 1'b0;
                    if (self_jump_d) begin
                        // pc already equals the target; park here.
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (halt) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    // resume alone decides; halt is not sampled here.
                    if (resume) begin
                        state_q    <= S_FETCH;
                        halted_q   <= 1'b0;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= S_FETCH;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign retired     = retired_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed scenarios followed by randomized stimulus, all checked every
//   cycle against a behavioural model of the sequencer kept in this file.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  localparam logic [15:0] RST_PC = 16'h0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [15:0] retired;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC), .HALT_ON_SELF_JUMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .jump_target(jump_target),
    .halt(halt), .resume(resume), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .halted(halted), .retired(retired),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  // Phase of the instruction lifecycle plus plain integer bookkeeping.
  typedef enum int {PH_FETCH, PH_EXEC, PH_HALT} phase_t;
  phase_t m_phase;
  int     m_pc;
  int     m_instr;
  int     m_retired;
  bit     m_live;   // at least one clock edge seen since reset release

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= PH_FETCH;
      m_pc      <= int'(RST_PC);
      m_instr   <= 0;
      m_retired <= 0;
      m_live    <= 1'b0;
    end else begin
      m_live <= 1'b1;
      case (m_phase)
        PH_FETCH: if (m_live && imem_ack) begin
          m_instr <= int'(imem_data);
          m_phase <= PH_EXEC;
        end
        PH_EXEC: begin
          m_retired <= (m_retired + 1) % 65536;
          if (jump && int'(jump_target) == m_pc) m_phase <= PH_HALT;
          else begin
            m_pc    <= jump ? int'(jump_target) : (m_pc + 1) % 65536;
            m_phase <= halt ? PH_HALT : PH_FETCH;
          end
        end
        default: if (resume) m_phase <= PH_FETCH;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("imem_req",    16'(imem_req),    16'((m_phase == PH_FETCH) && m_live));
    chk("instr_valid", 16'(instr_valid), 16'(m_phase == PH_EXEC));
    chk("halted",      16'(halted),      16'(m_phase == PH_HALT));
    chk("pc",          pc,               16'(m_pc));
    chk("imem_addr",   imem_addr,        16'(m_pc));
    chk("instr",       instr,            16'(m_instr));
    chk("retired",     retired,          16'(m_retired));
  endtask

  // ---------------- drivers ----------------
  // Set inputs just after a falling edge, then check at the next falling edge.
  task automatic step(input logic a, input logic j, input logic [15:0] t,
                      input logic h, input logic r);
    imem_ack    = a;
    jump        = j;
    jump_target = t;
    halt        = h;
    resume      = r;
    imem_data   = 16'($urandom);
    @(negedge clk);
    check_all();
  endtask

  // Fetch with zero wait, then execute with the given controls.
  task automatic instr_cycle(input logic j, input logic [15:0] t, input logic h);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, j, t, h, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, with ack held high throughout.
  task automatic async_reset(input int cycles);
    imem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all();
    chk("arst_req", 16'(imem_req), 16'h0000);
    chk("arst_pc",  pc, RST_PC);
    chk("arst_ret", retired, 16'h0000);
    repeat (cycles) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 check_all();
    chk("rst_pc",    pc, RST_PC);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch: first cycle after release has no request yet.
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("first_req", 16'(imem_req), 16'h0001);
    for (int i = 0; i < 3; i++) instr_cycle(1'b0, 16'h0000, 1'b0);
    chk("seq_pc", pc, 16'h0003);
    chk("seq_retired", retired, 16'h0003);

    // Self-jump at pc=5 halts; ack while halted is ignored; resume refetches.
    instr_cycle(1'b0, 16'h0000, 1'b0);
    instr_cycle(1'b0, 16'h0000, 1'b0);
    instr_cycle(1'b1, 16'h0005, 1'b0);
    chk("self_halted", 16'(halted), 16'h0001);
    chk("self_pc", pc, 16'h0005);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("halt_noreq", 16'(imem_req), 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("resume_req", 16'(imem_req), 16'h0001);
    chk("resume_addr", imem_addr, 16'h0005);

    // Wait states: ack after three idle request cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("wait_req", 16'(imem_req), 16'h0001);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("wait_valid", 16'(instr_valid), 16'h0001);
    // Taken jump to 0x0040.
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    chk("jump_addr", imem_addr, 16'h0040);

    // Wrap: jump to 0xFFFF, then sequential step to 0.
    instr_cycle(1'b1, 16'hFFFF, 1'b0);
    instr_cycle(1'b0, 16'h0000, 1'b0);
    chk("wrap_pc", pc, 16'h0000);

    // Halt held during fetch only takes effect at EXEC.
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("fetch_halt_ign", 16'(halted), 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("exec_halt", 16'(halted), 16'h0001);
    chk("exec_halt_pc", pc, 16'h0001);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("both_resume", 16'(halted), 16'h0000);

    // Reset mid-fetch at pc=0x0012.
    instr_cycle(1'b1, 16'h0012, 1'b0);
    chk("pre_rst_pc", pc, 16'h0012);
    async_reset(2);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic, including reset during any phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset($urandom_range(0, 2));
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      end else begin
        step($urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0,
             ($urandom_range(0, 3) == 0) ? 16'(m_pc) : 16'($urandom),
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
